opf_scoreboard: RTL and testbench

OPF_SCOREBOARD -- requirements
Module: opf_scoreboard

---
 rtl/opf_scoreboard_if.sv | 60 ++++++
 rtl/opf_scoreboard.sv | 210 +++++++++++++++++++++
 tb/tb_opf_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opf_scoreboard_if.sv
// rtl/opf_scoreboard_if.sv - issue-stage bundle: decode handshake, regbank read/writeback, issued operands
//
// Groups every non-clock/reset signal of opf_scoreboard.
//   slave  : the scoreboard itself (consumes decoded instructions, produces issued operands)
//   master : the surrounding pipeline / regbank (produces instructions and read data)
// Signals:
//   in_valid/in_ready           decoded-instruction handshake
//   instruction, NPC_in         raw instruction word and its next-PC
//   fmt, i_in, xu_in, tag_in    format, opcode class, execution unit, tag
//   mem_wr, mem_rd              instruction is a store / a load
//   addrA, addrB / dataA, dataB regbank read port (same-cycle data)
//   we, addrW                   writeback enable and one-hot writeback target [NREGS-1:1]
//   out_valid, opA..tag_out     issue pulse with operands and sideband
//   stall_cnt                   hazard-stall cycle counter
interface opf_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instruction;
   logic [XLEN-1:0]  NPC_in;
   logic [2:0]       fmt;
   logic [2:0]       i_in;
   logic [2:0]       xu_in;
   logic [3:0]       tag_in;
   logic             mem_wr;
   logic             mem_rd;
   logic [AW-1:0]    addrA;
   logic [AW-1:0]    addrB;
   logic [XLEN-1:0]  dataA;
   logic [XLEN-1:0]  dataB;
   logic             we;
   logic [NREGS-1:1] addrW;
   logic             out_valid;
   logic [XLEN-1:0]  opA;
   logic [XLEN-1:0]  opB;
   logic [XLEN-1:0]  opC;
   logic [XLEN-1:0]  NPC;
   logic [2:0]       i_out;
   logic [2:0]       xu_out;
   logic [3:0]       tag_out;
   logic [15:0]      stall_cnt;

   modport slave (
      input  in_valid, instruction, NPC_in, fmt, i_in, xu_in, tag_in, mem_wr, mem_rd,
      input  dataA, dataB, we,
      output in_ready, addrA, addrB, addrW,
      output out_valid, opA, opB, opC, NPC, i_out, xu_out, tag_out, stall_cnt
   );

   modport master (
      output in_valid, instruction, NPC_in, fmt, i_in, xu_in, tag_in, mem_wr, mem_rd,
      output dataA, dataB, we,
      input  in_ready, addrA, addrB, addrW,
      input  out_valid, opA, opB, opC, NPC, i_out, xu_out, tag_out, stall_cnt
   );
endinterface

// File: rtl/opf_scoreboard.sv
// rtl/opf_scoreboard.sv - operand-fetch scoreboard: holds one decoded instruction, stalls on locked sources, issues operands
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    opf_scoreboard_if.slave (handshake, regbank read/writeback, issued operands)
// Parameters: XLEN datapath width, NREGS register count (bit 0 of masks = memory-order lock),
//   TOKENS lock-queue depth (2..16): cycles a destination stays locked after issue.
// Optional feature: define OPF_STALL_CNT_EN to build the saturating hazard-stall counter;
//   otherwise stall_cnt is tied to zero.
module opf_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int TOKENS = 4
) (
   input  logic           clk,
   input  logic           reset,
   opf_scoreboard_if.slave bus
);

   localparam int AW = $clog2(NREGS);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   typedef enum logic {UNLOCK, LOCK} state_t;

   state_t state_q, state_d;

   // Held instruction; opcode bits [6:0] are never consulted so they are not stored.
   logic             held_valid_q, held_valid_d;
   logic [31:7]      instr_q;
   logic [XLEN-1:0]  npc_q;
   logic [2:0]       fmt_q, i_q, xu_q;
   logic [3:0]       tag_q;
   logic             mem_wr_q, mem_rd_q;

   logic [NREGS-1:0] lockq_q [TOKENS];
   logic [NREGS-1:0] locked;
   logic [NREGS-1:0] mask;

   logic [AW-1:0]    rs1, rs2, rd;
   logic             hazard, issue, accept, in_ready;
   logic [31:0]      imm32;
   logic [XLEN-1:0]  imm;

   logic             out_valid_q;
   logic [XLEN-1:0]  opA_q, opB_q, opC_q, npc_out_q;
   logic [2:0]       i_out_q, xu_out_q;
   logic [3:0]       tag_out_q;
   logic [NREGS-1:1] addrW_q;

   assign rs1 = instr_q[15 +: AW];
   assign rs2 = instr_q[20 +: AW];
   assign rd  = instr_q[7  +: AW];

   always_comb begin
      locked = '0;
      for (int k = 0; k < TOKENS; k++) locked = locked | lockq_q[k];
   end

   // x0 never blocks; bit 0 orders a load behind any in-flight store.
   assign hazard   = ((rs1 != '0) && locked[rs1]) ||
                     ((rs2 != '0) && locked[rs2]) ||
                     (mem_rd_q && locked[0]);
   assign issue    = held_valid_q && !hazard;
   assign in_ready = !held_valid_q || issue;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      held_valid_d = held_valid_q;
      case (state_q)
         UNLOCK:  if (held_valid_q && hazard) state_d = LOCK;
         LOCK:    if (!hazard) state_d = UNLOCK;
         default: state_d = UNLOCK;
      endcase
      if (accept)     held_valid_d = 1'b1;
      else if (issue) held_valid_d = 1'b0;
   end

   always_comb begin
      case (fmt_q)
         FMT_I:   imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
         FMT_S:   imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         FMT_B:   imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                           instr_q[11:8], 1'b0};
         FMT_U:   imm32 = {instr_q[31:12], 12'h000};
         FMT_J:   imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                           instr_q[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

   // Destination mask: one-hot rd (x0 excluded), bit 0 carries the store lock.
   always_comb begin
      mask = '0;
      if (rd != '0) mask[rd] = 1'b1;
      mask[0] = mem_wr_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= UNLOCK;
         held_valid_q <= 1'b0;
         instr_q      <= '0;
         npc_q        <= '0;
         fmt_q        <= '0;
         i_q          <= '0;
         xu_q         <= '0;
         tag_q        <= '0;
         mem_wr_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         held_valid_q <= held_valid_d;
         if (accept) begin
            instr_q  <= bus.instruction[31:7];
            npc_q    <= bus.NPC_in;
            fmt_q    <= bus.fmt;
            i_q      <= bus.i_in;
            xu_q     <= bus.xu_in;
            tag_q    <= bus.tag_in;
            mem_wr_q <= bus.mem_wr;
            mem_rd_q <= bus.mem_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < TOKENS; k++) lockq_q[k] <= '0;
      end else begin
         lockq_q[0] <= issue ? mask : '0;
         for (int k = 1; k < TOKENS; k++) lockq_q[k] <= lockq_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         opA_q       <= '0;
         opB_q       <= '0;
         opC_q       <= '0;
         npc_out_q   <= '0;
         i_out_q     <= '0;
         xu_out_q    <= '0;
         tag_out_q   <= '0;
         addrW_q     <= '0;
      end else begin
         // Writeback target leaves one slot before the lock expires.
         addrW_q <= bus.we ? lockq_q[TOKENS-2][NREGS-1:1] : '0;
         if (issue) begin
            out_valid_q <= 1'b1;
            opA_q       <= ((fmt_q == FMT_U) || (fmt_q == FMT_J)) ? npc_q : bus.dataA;
            opB_q       <= ((fmt_q == FMT_R) || (fmt_q == FMT_B)) ? bus.dataB : imm;
            opC_q       <= (fmt_q == FMT_S) ? bus.dataB : imm;
            npc_out_q   <= npc_q;
            i_out_q     <= i_q;
            xu_out_q    <= xu_q;
            tag_out_q   <= tag_q;
         end else begin
            out_valid_q <= 1'b0;
            opA_q       <= '0;
            opB_q       <= '0;
            opC_q       <= '0;
            npc_out_q   <= '0;
            i_out_q     <= '0;
            xu_out_q    <= '0;
            tag_out_q   <= '0;
         end
      end
   end

`ifdef OPF_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if ((state_q == LOCK) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = '0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.addrA     = rs1;
   assign bus.addrB     = rs2;
   assign bus.addrW     = addrW_q;
   assign bus.out_valid = out_valid_q;
   assign bus.opA       = opA_q;
   assign bus.opB       = opB_q;
   assign bus.opC       = opC_q;
   assign bus.NPC       = npc_out_q;
   assign bus.i_out     = i_out_q;
   assign bus.xu_out    = xu_out_q;
   assign bus.tag_out   = tag_out_q;

endmodule

// File: tb/tb_opf_scoreboard.sv
// tb/tb_opf_scoreboard.sv - self-checking bench for opf_scoreboard: directed scenarios plus random traffic against a cycle-history model
module tb_opf_scoreboard;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int TOKENS = 4;

   localparam logic [2:0] F_R = 3'd0;
   localparam logic [2:0] F_I = 3'd1;
   localparam logic [2:0] F_S = 3'd2;
   localparam logic [2:0] F_B = 3'd3;
   localparam logic [2:0] F_U = 3'd4;
   localparam logic [2:0] F_J = 3'd5;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   opf_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

   opf_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .TOKENS(TOKENS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [XLEN-1:0] rf [NREGS];
   assign bus.dataA = rf[bus.addrA];
   assign bus.dataB = rf[bus.addrB];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit              v;
      logic [31:0]     ins;
      logic [XLEN-1:0] npc;
      logic [2:0]      fmt, i, xu;
      logic [3:0]      tag;
      bit              mw, mr;
   } held_t;

   held_t           h;
   longint          cyc = 0;
   logic [NREGS-1:0] issued_mask [longint];   // mask issued in a given cycle
   int              stall_total;
   bit              e_ov;
   logic [XLEN-1:0] e_opA, e_opB, e_opC, e_npc;
   logic [2:0]      e_i, e_xu;
   logic [3:0]      e_tag;
   logic [NREGS-1:1] e_addrW;
   logic [15:0]     e_stall;

   function automatic logic [31:0] m_imm(input logic [31:0] x, input logic [2:0] f);
      logic [31:0] r;
      case (f)
         F_I:     r = {{20{x[31]}}, x[31:20]};
         F_S:     r = {{20{x[31]}}, x[31:25], x[11:7]};
         F_B:     r = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
         F_U:     r = x & 32'hFFFF_F000;
         F_J:     r = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      h = '{default: '0};
      issued_mask.delete();
      stall_total = 0;
      e_ov = 0; e_opA = '0; e_opB = '0; e_opC = '0; e_npc = '0;
      e_i = '0; e_xu = '0; e_tag = '0; e_addrW = '0; e_stall = '0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      logic [NREGS-1:0] lk, old;
      logic [4:0] rs1, rs2, rd;
      bit hz, iss, rdy, stall;
      if (!reset) begin
         model_reset();
         chk("rst_out_valid", bus.out_valid, 0);
      end else begin
         lk = '0;
         for (int k = 1; k <= TOKENS; k++)
            if (issued_mask.exists(cyc - k)) lk |= issued_mask[cyc - k];
         rs1 = h.ins[19:15]; rs2 = h.ins[24:20]; rd = h.ins[11:7];
         hz  = (rs1 != 0 && lk[rs1]) || (rs2 != 0 && lk[rs2]) || (h.mr && lk[0]);
         iss = h.v && !hz;
         rdy = !h.v || iss;
         stall = h.v && hz;

         chk("in_ready",  bus.in_ready,  rdy);
         chk("addrA",     bus.addrA,     rs1);
         chk("addrB",     bus.addrB,     rs2);
         chk("out_valid", bus.out_valid, e_ov);
         chk("opA",       bus.opA,       e_opA);
         chk("opB",       bus.opB,       e_opB);
         chk("opC",       bus.opC,       e_opC);
         chk("NPC",       bus.NPC,       e_npc);
         chk("i_out",     bus.i_out,     e_i);
         chk("xu_out",    bus.xu_out,    e_xu);
         chk("tag_out",   bus.tag_out,   e_tag);
         chk("addrW",     bus.addrW,     e_addrW);
         chk("stall_cnt", bus.stall_cnt, e_stall);

         if (iss) begin
            e_ov  = 1;
            e_opA = (h.fmt == F_U || h.fmt == F_J) ? h.npc : rf[rs1];
            e_opB = (h.fmt == F_R || h.fmt == F_B) ? rf[rs2] : m_imm(h.ins, h.fmt);
            e_opC = (h.fmt == F_S) ? rf[rs2] : m_imm(h.ins, h.fmt);
            e_npc = h.npc; e_i = h.i; e_xu = h.xu; e_tag = h.tag;
            issued_mask[cyc] = ((rd != 0) ? (NREGS'(1) << rd) : '0) | NREGS'(h.mw);
         end else begin
            e_ov = 0; e_opA = '0; e_opB = '0; e_opC = '0; e_npc = '0;
            e_i = '0; e_xu = '0; e_tag = '0;
         end

         // Writeback shows the mask issued TOKENS-1 cycles ago, delayed one cycle.
         old = issued_mask.exists(cyc + 1 - TOKENS) ? issued_mask[cyc + 1 - TOKENS] : '0;
         e_addrW = bus.we ? old[NREGS-1:1] : '0;

`ifdef OPF_STALL_CNT_EN
         e_stall = (stall_total > 65535) ? 16'hFFFF : 16'(stall_total);
         if (stall) stall_total++;
`else
         e_stall = '0;
`endif

         if (bus.in_valid && rdy) begin
            h.v = 1; h.ins = bus.instruction; h.npc = bus.NPC_in; h.fmt = bus.fmt;
            h.i = bus.i_in; h.xu = bus.xu_in; h.tag = bus.tag_in;
            h.mw = bus.mem_wr; h.mr = bus.mem_rd;
         end else if (iss) begin
            h.v = 0;
         end
         if (issued_mask.exists(cyc - TOKENS - 2)) issued_mask.delete(cyc - TOKENS - 2);
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [31:0] ins, input logic [2:0] f, input bit mw, input bit mr);
      bit r = 0;
      bus.in_valid = 1; bus.instruction = ins; bus.fmt = f;
      bus.mem_wr = mw; bus.mem_rd = mr;
      bus.NPC_in = $urandom; bus.i_in = 3'($urandom); bus.xu_in = 3'($urandom);
      bus.tag_in = 4'($urandom);
      for (int n = 0; n < 64; n++) begin
         @(negedge clk); r = bus.in_ready;
         @(posedge clk);
         if (r) break;
      end
      if (!r) begin
         n_checks++;
         $display("FAIL send_timeout: instruction %h not accepted within 64 cycles", ins);
      end
      #1 bus.in_valid = 0;
   endtask

   task automatic count_stall(output int n);
      n = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int st;
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      for (int r = 0; r < NREGS; r++) rf[r] = $urandom;
      rf[0] = '0;
      bus.in_valid = 0; bus.instruction = '0; bus.NPC_in = '0; bus.fmt = '0;
      bus.i_in = '0; bus.xu_in = '0; bus.tag_in = '0; bus.mem_wr = 0; bus.mem_rd = 0;
      bus.we = 1;
      reset = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2 reset = 1;
      @(negedge clk);
      chk("reset_in_ready",  bus.in_ready,  1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_stall_cnt", bus.stall_cnt, 0);
      chk("reset_addrW",     bus.addrW,     0);
      @(posedge clk); #1;

      // addi x5,x0,7 issues next cycle with opB = 7
      send(32'h00700293, F_I, 0, 0);
      @(negedge clk); chk("addi_ov_early", bus.out_valid, 0);
      @(negedge clk); chk("addi_ov", bus.out_valid, 1);
      chk("addi_opB", bus.opB, 32'h00000007);
      @(posedge clk); #1;
      idle(TOKENS + 2);

      // add x6,x5,x5 right behind the x5 writer stalls TOKENS cycles
      send(32'h00700293, F_I, 0, 0);
      send(32'h00528333, F_R, 0, 0);
      count_stall(st); chk("raw_stall", st, TOKENS);
      idle(TOKENS + 2);

      // sw then lw: load stalls on the memory-order lock
      send(32'h0020A023, F_S, 1, 0);
      send(32'h0000A183, F_I, 0, 1);
      count_stall(st); chk("sw_lw_stall", st, TOKENS);
      idle(TOKENS + 2);

      // rd = x0: no lock, readers of x0 and loads proceed
      send(32'h00100013, F_I, 0, 0);
      send(32'h000003B3, F_R, 0, 0);
      count_stall(st); chk("x0_reader_stall", st, 0);
      idle(TOKENS + 2);
      send(32'h00100013, F_I, 0, 0);
      send(32'h0000A183, F_I, 0, 1);
      count_stall(st); chk("x0_load_stall", st, 0);
      idle(TOKENS + 2);

      // reset asserted while stalled
      send(32'h00700293, F_I, 0, 0);
      send(32'h00528333, F_R, 0, 0);
      @(negedge clk); @(negedge clk);
      #2 reset = 0;
      #1;
      chk("rst_lock_out_valid", bus.out_valid, 0);
      chk("rst_lock_opA",       bus.opA,       0);
      chk("rst_lock_opB",       bus.opB,       0);
      chk("rst_lock_addrW",     bus.addrW,     0);
      chk("rst_lock_stall_cnt", bus.stall_cnt, 0);
      chk("rst_lock_in_ready",  bus.in_ready,  1);
      repeat (2) @(negedge clk);
      #2 reset = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); chk("post_rst_no_issue", bus.out_valid, 0);
      end
      @(posedge clk); #1;

      // three-cycle stall: writer, independent filler, dependent reader
      send(32'h00700293, F_I, 0, 0);
      send(32'h00100493, F_I, 0, 0);
      send(32'h00528333, F_R, 0, 0);
      count_stall(st); chk("stall3_cycles", st, 3);
      idle(3);
`ifdef OPF_STALL_CNT_EN
      chk("stall3_cnt", bus.stall_cnt, 3);
`else
      chk("stall3_cnt", bus.stall_cnt, 0);
`endif
      idle(TOKENS + 2);

      // random traffic over a small register window to provoke hazards
      for (int c = 0; c < 2500; c++) begin
         logic [31:0] ins;
         int m;
         ins = $urandom;
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         ins[11:7]  = 5'($urandom_range(0, 7));
         m = $urandom_range(0, 3);
         bus.in_valid    = ($urandom_range(0, 3) != 0);
         bus.instruction = ins;
         bus.fmt         = 3'($urandom_range(0, 7));
         bus.mem_wr      = (m == 0);
         bus.mem_rd      = (m == 1);
         bus.NPC_in      = $urandom;
         bus.i_in        = 3'($urandom);
         bus.xu_in       = 3'($urandom);
         bus.tag_in      = 4'($urandom);
         bus.we          = $urandom_range(0, 1) == 1;
         @(posedge clk); #1;
      end
      bus.in_valid = 0;
      idle(TOKENS + 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
